usb_fs_rx_decoder: RTL and testbench

- Full-speed USB receiver front end: the receive end of the link our USB transmitter drives on tx_d_plus/tx_d_minus.
- Oversamples the differential pair, recovers bit timing, and detects SYNC.
- NRZI-decodes, removes stuffed bits, assembles bytes LSB-first and detects EOP.
- Emits one-cycle byte strobes plus packet start/done/error flags to downstream packet logic.

---
 rtl/usb_fs_rx_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_usb_fs_rx_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_rx_decoder.sv
// Full-speed USB receive front end: oversamples D+/D-, recovers bit timing,
// NRZI-decodes, removes stuffed bits and frames bytes between SYNC and EOP.
module usb_fs_rx_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int IDLE_BITS    = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx_d_plus,
    input  logic       rx_d_minus,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_active,
    output logic       rx_packet_done,
    output logic       rx_error
);
    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_SAMPLE = PW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDLE_LAST    = IW'(IDLE_BITS - 1);

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_RECV = 3'd2;
    localparam logic [2:0] ST_EOP1 = 3'd3;
    localparam logic [2:0] ST_EOP2 = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    logic          dp_meta_q, dp_meta_d, dp_sync_q, dp_sync_d;
    logic          dm_meta_q, dm_meta_d, dm_sync_q, dm_sync_d;
    logic          dp_last_q, dp_last_d;
    logic [1:0]    prev_line_q, prev_line_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    ones_q, ones_d;
    logic [7:0]    shift_q, shift_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_data_valid_q, rx_data_valid_d;
    logic          rx_active_q, rx_active_d;
    logic          rx_packet_done_q, rx_packet_done_d;
    logic          rx_error_q, rx_error_d;

    logic       line_se0, line_j, line_k;
    logic [1:0] cur_line;
    logic       sample, nrzi_bit, go_err;

    always_comb begin
        dp_meta_d = rx_d_plus;
        dm_meta_d = rx_d_minus;
        dp_sync_d = dp_meta_q;
        dm_sync_d = dm_meta_q;
        dp_last_d = dp_sync_q;

        line_se0 = (dp_sync_q == dm_sync_q);
        line_j   = dp_sync_q & ~dm_sync_q;
        line_k   = ~dp_sync_q & dm_sync_q;
        cur_line = line_se0 ? LINE_SE0 : {dp_sync_q, dm_sync_q};
        nrzi_bit = (cur_line == prev_line_q);
        sample   = (phase_q == PHASE_SAMPLE);

        // Re-centre on every J/K transition so the sample lands mid-bit.
        if ((dp_sync_q != dp_last_q) && !line_se0) begin
            phase_d = '0;
        end else if (phase_q == PHASE_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    always_comb begin
        prev_line_d      = prev_line_q;
        state_d          = state_q;
        bit_cnt_d        = bit_cnt_q;
        ones_d           = ones_q;
        shift_d          = shift_q;
        idle_cnt_d       = idle_cnt_q;
        rx_data_d        = rx_data_q;
        rx_active_d      = rx_active_q;
        rx_data_valid_d  = 1'b0;
        rx_packet_done_d = 1'b0;
        rx_error_d       = 1'b0;
        go_err           = 1'b0;

        if (sample) begin
            prev_line_d = cur_line;
            case (state_q)
                ST_IDLE: begin
                    if (line_k) begin
                        state_d   = ST_SYNC;
                        bit_cnt_d = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (line_se0 || (nrzi_bit != (bit_cnt_q == 3'd7))) begin
                        go_err = 1'b1;
                    end else if (bit_cnt_q == 3'd7) begin
                        // The trailing SYNC 1 already counts toward the stuffing run.
                        state_d     = ST_RECV;
                        rx_active_d = 1'b1;
                        shift_d     = '0;
                        bit_cnt_d   = '0;
                        ones_d      = 3'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_RECV: begin
                    if (line_se0) begin
                        if (bit_cnt_q == 3'd0) begin
                            state_d = ST_EOP1;
                        end else begin
                            go_err = 1'b1;
                        end
                    end else if (ones_q == 3'd6) begin
                        if (nrzi_bit) begin
                            go_err = 1'b1;
                        end else begin
                            ones_d = '0;
                        end
                    end else begin
                        ones_d    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                        shift_d   = {nrzi_bit, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d       = {nrzi_bit, shift_q[7:1]};
                            rx_data_valid_d = 1'b1;
                        end
                    end
                end
                ST_EOP1: begin
                    if (line_se0) begin
                        state_d = ST_EOP2;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                ST_EOP2: begin
                    if (line_j) begin
                        rx_packet_done_d = 1'b1;
                        rx_active_d      = 1'b0;
                        state_d          = ST_IDLE;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                ST_ERR: begin
                    if (line_j) begin
                        if (idle_cnt_q == IDLE_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            idle_cnt_d = idle_cnt_q + IW'(1);
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (go_err) begin
                state_d     = ST_ERR;
                rx_error_d  = 1'b1;
                rx_active_d = 1'b0;
                idle_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta_q        <= 1'b1;
            dp_sync_q        <= 1'b1;
            dm_meta_q        <= 1'b0;
            dm_sync_q        <= 1'b0;
            dp_last_q        <= 1'b1;
            prev_line_q      <= LINE_J;
            phase_q          <= '0;
            state_q          <= ST_IDLE;
            bit_cnt_q        <= '0;
            ones_q           <= '0;
            shift_q          <= '0;
            idle_cnt_q       <= '0;
            rx_data_q        <= '0;
            rx_data_valid_q  <= 1'b0;
            rx_active_q      <= 1'b0;
            rx_packet_done_q <= 1'b0;
            rx_error_q       <= 1'b0;
        end else begin
            dp_meta_q        <= dp_meta_d;
            dp_sync_q        <= dp_sync_d;
            dm_meta_q        <= dm_meta_d;
            dm_sync_q        <= dm_sync_d;
            dp_last_q        <= dp_last_d;
            prev_line_q      <= prev_line_d;
            phase_q          <= phase_d;
            state_q          <= state_d;
            bit_cnt_q        <= bit_cnt_d;
            ones_q           <= ones_d;
            shift_q          <= shift_d;
            idle_cnt_q       <= idle_cnt_d;
            rx_data_q        <= rx_data_d;
            rx_data_valid_q  <= rx_data_valid_d;
            rx_active_q      <= rx_active_d;
            rx_packet_done_q <= rx_packet_done_d;
            rx_error_q       <= rx_error_d;
        end
    end

    assign rx_data        = rx_data_q;
    assign rx_data_valid  = rx_data_valid_q;
    assign rx_active      = rx_active_q;
    assign rx_packet_done = rx_packet_done_q;
    assign rx_error       = rx_error_q;
endmodule

// File: tb/tb_usb_fs_rx_decoder.sv
// Bench for usb_fs_rx_decoder: encodes payloads into USB line symbols (SYNC, NRZI,
// stuffing, EOP) and compares the decoded stream against the payloads it sent.
module tb_usb_fs_rx_decoder;
    localparam int CPB       = 8;
    localparam int IDLE_BITS = 8;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       rx_d_plus = 1'b1;
    logic       rx_d_minus = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_valid, rx_active, rx_packet_done, rx_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_bytes[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int active_cycles = 0;
    int inactive_strobes = 0;
    int both_cnt = 0;

    logic [1:0] line_q[$];
    logic [7:0] exp_q[$];
    logic [1:0] enc_level;
    int         enc_ones;
    int         drift;
    bit         alt_flag;

    int b0, d0, e0, a0, s0;

    usb_fs_rx_decoder #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDLE_BITS)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .rx_d_plus(rx_d_plus),
        .rx_d_minus(rx_d_minus),
        .rx_data(rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_active(rx_active),
        .rx_packet_done(rx_packet_done),
        .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    // Event monitor: every output pulse is recorded on the falling edge.
    always @(negedge clk) begin
        if (rx_data_valid) begin
            got_bytes.push_back(rx_data);
            if (!rx_active) inactive_strobes++;
        end
        if (rx_packet_done) done_cnt++;
        if (rx_error) err_cnt++;
        if (rx_packet_done && rx_error) both_cnt++;
        if (rx_active) active_cycles++;
    end

    task automatic push_sym(input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) line_q.push_back(s);
    endtask

    task automatic push_sync();
        push_sym(LK, 1); push_sym(LJ, 1); push_sym(LK, 1); push_sym(LJ, 1);
        push_sym(LK, 1); push_sym(LJ, 1); push_sym(LK, 2);
        enc_level = LK;
        enc_ones  = 1;
    endtask

    task automatic push_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            if (b[i]) begin
                enc_ones++;
            end else begin
                enc_level = (enc_level == LJ) ? LK : LJ;
                enc_ones  = 0;
            end
            line_q.push_back(enc_level);
            if (enc_ones == 6) begin
                enc_level = (enc_level == LJ) ? LK : LJ;
                enc_ones  = 0;
                line_q.push_back(enc_level);
            end
        end
    endtask

    task automatic push_eop();
        push_sym(LSE0, 2);
        push_sym(LJ, 1);
    endtask

    // mode 0: nominal bit time, 1: alternating 7/9 clks, 2: random +/-1 with bounded drift
    task automatic send(input int mode, input int limit);
        int n;
        int period;
        int r;
        logic [1:0] s;
        n = 0;
        drift = 0;
        while (line_q.size() > 0 && (limit < 0 || n < limit)) begin
            s = line_q.pop_front();
            if (mode == 1) begin
                period = alt_flag ? CPB + 1 : CPB - 1;
                alt_flag = ~alt_flag;
            end else if (mode == 2) begin
                r = int'($urandom_range(0, 2)) - 1;
                if (drift + r > 1 || drift + r < -1) r = -r;
                drift += r;
                period = CPB + r;
            end else begin
                period = CPB;
            end
            {rx_d_plus, rx_d_minus} = s;
            repeat (period) @(negedge clk);
            n++;
        end
        line_q.delete();
    endtask

    task automatic snap();
        b0 = got_bytes.size();
        d0 = done_cnt;
        e0 = err_cnt;
        a0 = active_cycles;
        s0 = inactive_strobes;
    endtask

    task automatic test_reset();
        #2 n_rst = 1'b0;
        #2;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data: got %0h expected 0", rx_data); end
        checks++; if (rx_data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", rx_data_valid); end
        checks++; if (rx_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %0b expected 0", rx_active); end
        checks++; if (rx_packet_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", rx_packet_done); end
        checks++; if (rx_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %0b expected 0", rx_error); end
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        snap();
        push_sym(LJ, 16);
        send(0, -1);
        checks++; if (done_cnt - d0 + err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL idle_pulses: got %0d expected 0", done_cnt - d0 + err_cnt - e0); end
        checks++; if (active_cycles - a0 !== 0) begin errors++; $display("[TB] FAIL idle_active: got %0d expected 0", active_cycles - a0); end
    endtask

    task automatic test_single_byte();
        snap();
        push_sym(LJ, 4); push_sync(); push_bits(8'hA5, 8); push_eop(); push_sym(LJ, 12);
        send(0, -1);
        checks++; if (got_bytes.size() - b0 !== 1) begin errors++; $display("[TB] FAIL a5_count: got %0d expected 1", got_bytes.size() - b0); end
        if (got_bytes.size() > b0) begin
            checks++; if (got_bytes[b0] !== 8'hA5) begin errors++; $display("[TB] FAIL a5_value: got %0h expected a5", got_bytes[b0]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL a5_done: got %0d expected 1", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL a5_error: got %0d expected 0", err_cnt - e0); end
        checks++; if (inactive_strobes - s0 !== 0) begin errors++; $display("[TB] FAIL a5_active_at_strobe: got %0d strobes without rx_active expected 0", inactive_strobes - s0); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL a5_hold: got %0h expected a5", rx_data); end
        checks++; if (rx_active !== 1'b0) begin errors++; $display("[TB] FAIL a5_active_after: got %0b expected 0", rx_active); end
    endtask

    task automatic test_stuffing();
        snap();
        exp_q = '{8'hFF, 8'h00};
        push_sync(); push_bits(8'hFF, 8); push_bits(8'h00, 8); push_eop(); push_sym(LJ, 12);
        send(0, -1);
        checks++; if (got_bytes.size() - b0 !== 2) begin errors++; $display("[TB] FAIL stuff_count: got %0d expected 2", got_bytes.size() - b0); end
        for (int i = 0; i < 2; i++) begin
            if (b0 + i < got_bytes.size()) begin
                checks++; if (got_bytes[b0 + i] !== exp_q[i]) begin errors++; $display("[TB] FAIL stuff_byte%0d: got %0h expected %0h", i, got_bytes[b0 + i], exp_q[i]); end
            end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL stuff_done: got %0d expected 1", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL stuff_error: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_stuff_error();
        // Too short a J gap: the following packet must be ignored.
        snap();
        push_sync(); push_sym(LK, 7); push_sym(LJ, IDLE_BITS - 1);
        push_sync(); push_bits(8'h3C, 8); push_eop(); push_sym(LJ, 16);
        send(0, -1);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL stufferr_short_errors: got %0d expected 1", err_cnt - e0); end
        checks++; if (got_bytes.size() - b0 !== 0) begin errors++; $display("[TB] FAIL stufferr_short_bytes: got %0d expected 0", got_bytes.size() - b0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("[TB] FAIL stufferr_short_done: got %0d expected 0", done_cnt - d0); end
        // Exactly IDLE_BITS J bits: recovery in time for the next packet.
        snap();
        push_sync(); push_sym(LK, 7); push_sym(LJ, IDLE_BITS);
        push_sync(); push_bits(8'h3C, 8); push_eop(); push_sym(LJ, 16);
        send(0, -1);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL stufferr_exact_errors: got %0d expected 1", err_cnt - e0); end
        checks++; if (got_bytes.size() - b0 !== 1) begin errors++; $display("[TB] FAIL stufferr_exact_bytes: got %0d expected 1", got_bytes.size() - b0); end
        if (got_bytes.size() > b0) begin
            checks++; if (got_bytes[b0] !== 8'h3C) begin errors++; $display("[TB] FAIL stufferr_exact_value: got %0h expected 3c", got_bytes[b0]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL stufferr_exact_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_bad_sync();
        snap();
        push_sym(LK, 1); push_sym(LJ, 1); push_sym(LK, 1); push_sym(LJ, 1); push_sym(LK, 4);
        push_sym(LJ, 12);
        send(0, -1);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL badsync_error: got %0d expected 1", err_cnt - e0); end
        checks++; if (active_cycles - a0 !== 0) begin errors++; $display("[TB] FAIL badsync_active: got %0d cycles expected 0", active_cycles - a0); end
        snap();
        push_sync(); push_bits(8'h3C, 8); push_eop(); push_sym(LJ, 12);
        send(0, -1);
        checks++; if (got_bytes.size() - b0 !== 1) begin errors++; $display("[TB] FAIL badsync_next_count: got %0d expected 1", got_bytes.size() - b0); end
        if (got_bytes.size() > b0) begin
            checks++; if (got_bytes[b0] !== 8'h3C) begin errors++; $display("[TB] FAIL badsync_next_value: got %0h expected 3c", got_bytes[b0]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL badsync_next_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_jitter();
        snap();
        exp_q = '{8'h12, 8'h34, 8'h56};
        alt_flag = 1'b0;
        push_sync();
        foreach (exp_q[i]) push_bits(exp_q[i], 8);
        push_eop(); push_sym(LJ, 12);
        send(1, -1);
        checks++; if (got_bytes.size() - b0 !== 3) begin errors++; $display("[TB] FAIL jitter_count: got %0d expected 3", got_bytes.size() - b0); end
        for (int i = 0; i < 3; i++) begin
            if (b0 + i < got_bytes.size()) begin
                checks++; if (got_bytes[b0 + i] !== exp_q[i]) begin errors++; $display("[TB] FAIL jitter_byte%0d: got %0h expected %0h", i, got_bytes[b0 + i], exp_q[i]); end
            end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL jitter_done: got %0d expected 1", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL jitter_error: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_zero_length();
        snap();
        push_sync(); push_eop(); push_sym(LJ, 12);
        send(0, -1);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL zlp_done: got %0d expected 1", done_cnt - d0); end
        checks++; if (got_bytes.size() - b0 !== 0) begin errors++; $display("[TB] FAIL zlp_bytes: got %0d expected 0", got_bytes.size() - b0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL zlp_error: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_bad_eop();
        snap();
        push_sync(); push_bits(8'h5A, 8); push_bits(8'h00, 3); push_eop(); push_sym(LJ, 16);
        send(0, -1);
        checks++; if (got_bytes.size() - b0 !== 1) begin errors++; $display("[TB] FAIL midse0_bytes: got %0d expected 1", got_bytes.size() - b0); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL midse0_error: got %0d expected 1", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("[TB] FAIL midse0_done: got %0d expected 0", done_cnt - d0); end
        snap();
        push_sync(); push_bits(8'h11, 8); push_sym(LSE0, 3); push_sym(LJ, 16);
        send(0, -1);
        checks++; if (got_bytes.size() - b0 !== 1) begin errors++; $display("[TB] FAIL longse0_bytes: got %0d expected 1", got_bytes.size() - b0); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL longse0_error: got %0d expected 1", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("[TB] FAIL longse0_done: got %0d expected 0", done_cnt - d0); end
    endtask

    task automatic test_reset_midpacket();
        snap();
        push_sync(); push_bits(8'hC3, 8);
        send(0, 12);
        checks++; if (rx_active !== 1'b1) begin errors++; $display("[TB] FAIL midrst_active_before: got %0b expected 1", rx_active); end
        #3 n_rst = 1'b0;
        {rx_d_plus, rx_d_minus} = LJ;
        #1;
        checks++; if ({rx_data, rx_data_valid, rx_active, rx_packet_done, rx_error} !== 12'h000) begin
            errors++; $display("[TB] FAIL midrst_outputs: got data=%0h v=%0b a=%0b d=%0b e=%0b expected all 0",
                               rx_data, rx_data_valid, rx_active, rx_packet_done, rx_error);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        push_sym(LJ, 12); push_sync(); push_bits(8'h81, 8); push_eop(); push_sym(LJ, 12);
        send(0, -1);
        checks++; if (got_bytes.size() - b0 !== 1) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 1", got_bytes.size() - b0); end
        if (got_bytes.size() > b0) begin
            checks++; if (got_bytes[b0] !== 8'h81) begin errors++; $display("[TB] FAIL midrst_value: got %0h expected 81", got_bytes[b0]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL midrst_done: got %0d expected 1", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL midrst_error: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_random_packets();
        int len;
        logic [7:0] b;
        snap();
        exp_q.delete();
        for (int p = 0; p < 8; p++) begin
            len = int'($urandom_range(0, 4));
            push_sync();
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                push_bits(b, 8);
            end
            push_eop();
            push_sym(LJ, int'($urandom_range(4, 10)));
            send(2, -1);
        end
        checks++; if (got_bytes.size() - b0 !== exp_q.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", got_bytes.size() - b0, exp_q.size()); end
        foreach (exp_q[i]) begin
            if (b0 + i < got_bytes.size()) begin
                checks++; if (got_bytes[b0 + i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand_byte%0d: got %0h expected %0h", i, got_bytes[b0 + i], exp_q[i]); end
            end
        end
        checks++; if (done_cnt - d0 !== 8) begin errors++; $display("[TB] FAIL rand_done: got %0d expected 8", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL rand_error: got %0d expected 0", err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_stuffing();
        test_stuff_error();
        test_bad_sync();
        test_jitter();
        test_zero_length();
        test_bad_eop();
        test_reset_midpacket();
        test_random_packets();
        checks++; if (both_cnt !== 0) begin errors++; $display("[TB] FAIL done_and_error_same_cycle: got %0d expected 0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
